// File: rtl/falafel_pkg.sv
// falafel_pkg: shared widths, constants and request/response types for the falafel LSU
package falafel_pkg;
  localparam int DATA_W = 64;
  localparam logic [DATA_W-1:0] WORD_BYTES = DATA_W'(DATA_W / 8);
  localparam logic [DATA_W-1:0] LOCK_ADDR = '0;

  typedef enum logic [2:0] {
    LOAD                    = 3'd0,
    EDIT_NEXT_ADDR          = 3'd1,
    EDIT_SIZE_AND_NEXT_ADDR = 3'd2,
    LOCK                    = 3'd3,
    UNLOCK                  = 3'd4
  } req_lsu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] size;
    logic [DATA_W-1:0] next_addr;
  } header_t;

  typedef struct packed {
    header_t     header;
    req_lsu_op_e lsu_op;
    logic        val;
  } header_req_t;

  typedef struct packed {
    header_t header;
    logic    val;
  } header_rsp_t;
endpackage

// File: rtl/falafel_mem_port.sv
// falafel_mem_port: single-outstanding req/gnt/rvalid sequencer driven by a level start
module falafel_mem_port
  import falafel_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start,
  input  logic              we,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  logic pend;

  assign mem_req_o   = start & ~pend;
  assign mem_we_o    = start & we;
  assign mem_addr_o  = start ? addr : '0;
  assign mem_wdata_o = start ? wdata : '0;
  assign rdata       = mem_rdata_i;
  assign done        = we ? mem_req_o & mem_gnt_i
                          : start & mem_rvalid_i & (pend | (mem_req_o & mem_gnt_i));

  // a granted read without same-cycle rvalid stays pending; stray rvalid outside a read is ignored
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pend <= 1'b0;
    else if (mem_req_o & mem_gnt_i & ~we & ~mem_rvalid_i) pend <= 1'b1;
    else if (mem_rvalid_i) pend <= 1'b0;
  end
endmodule

// File: rtl/falafel_lsu.sv
// falafel_lsu: header load/edit and lock/unlock sequencer over a single memory port
module falafel_lsu
  import falafel_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  header_req_t       req_i,
  output logic              lsu_ready_o,
  output header_rsp_t       rsp_o,
  input  logic              core_ready_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_lock_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  typedef enum logic [3:0] {
    IDLE, RD_SIZE, RD_NEXT, WR_SIZE, WR_NEXT, LOCK_RD, LOCK_WR, UNLOCK_WR, RSP
  } state_e;

  state_e            state, state_nx;
  header_t           hdr;
  req_lsu_op_e       op;
  logic              start, we, done;
  logic [DATA_W-1:0] addr, wdata, rdata;

  // next-state: each access state advances only when its memory transaction completes
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:
        if (req_i.val)
          case (req_i.lsu_op)
            LOAD:                    state_nx = RD_SIZE;
            EDIT_NEXT_ADDR:          state_nx = WR_NEXT;
            EDIT_SIZE_AND_NEXT_ADDR: state_nx = WR_SIZE;
            LOCK:                    state_nx = LOCK_RD;
            UNLOCK:                  state_nx = UNLOCK_WR;
            default:                 state_nx = RSP;
          endcase
      RD_SIZE:                       state_nx = done ? RD_NEXT : state;
      WR_SIZE:                       state_nx = done ? WR_NEXT : state;
      RD_NEXT, WR_NEXT, LOCK_WR, UNLOCK_WR: state_nx = done ? RSP : state;
      LOCK_RD:                       state_nx = done && rdata == '0 ? LOCK_WR : state;
      RSP:                           state_nx = core_ready_i ? IDLE : state;
      default:                       state_nx = IDLE;
    endcase
  end

  // memory access decode and response outputs, all derived from state and captured header
  always_comb begin
    start       = !(state inside {IDLE, RSP});
    we          = state inside {WR_SIZE, WR_NEXT, LOCK_WR, UNLOCK_WR};
    addr        = state inside {RD_SIZE, WR_SIZE} ? hdr.addr
                : state inside {RD_NEXT, WR_NEXT} ? hdr.addr + WORD_BYTES : LOCK_ADDR;
    wdata       = state == WR_SIZE ? hdr.size
                : state == WR_NEXT ? hdr.next_addr
                : state == LOCK_WR ? DATA_W'(1) : '0;
    mem_lock_o  = state inside {LOCK_RD, LOCK_WR};
    lsu_ready_o = state == IDLE;
    rsp_o.val    = state == RSP;
    rsp_o.header = state == RSP && op inside {LOAD, EDIT_NEXT_ADDR, EDIT_SIZE_AND_NEXT_ADDR}
                 ? hdr : '0;
  end

  // state register, request capture on accept, and load data capture on read completion
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      hdr   <= '0;
      op    <= LOAD;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_i.val) begin
        hdr <= req_i.header;
        op  <= req_i.lsu_op;
      end
      if (state == RD_SIZE && done) hdr.size <= rdata;
      if (state == RD_NEXT && done) hdr.next_addr <= rdata;
    end
  end

  falafel_mem_port u_port (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start       (start),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .done        (done),
    .rdata       (rdata),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i)
  );
endmodule

// File: tb/tb_falafel_lsu.sv
// tb_falafel_lsu: scoreboard bench with a memory responder and a header-level reference model
module tb_falafel_lsu;
  import falafel_pkg::*;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  header_req_t       req_i;
  logic              lsu_ready_o;
  header_rsp_t       rsp_o;
  logic              core_ready_i;
  logic              mem_req_o, mem_we_o, mem_lock_o, mem_gnt_i, mem_rvalid_i;
  logic [DATA_W-1:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  always #5 clk = ~clk;

  falafel_lsu dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .lsu_ready_o (lsu_ready_o),
    .rsp_o       (rsp_o),
    .core_ready_i(core_ready_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_lock_o  (mem_lock_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i)
  );

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  int tests = 0, fails = 0;
  logic [DATA_W-1:0] mem [logic [DATA_W-1:0]];
  logic [DATA_W-1:0] ref_mem [logic [DATA_W-1:0]];
  header_t exp_q[$];
  wr_t wr_log[$];
  int gmode = 0, spin = 0, lock_reads = 0;
  bit stall_en = 0, inject = 0, cr_rand = 0, cr_val = 1;
  logic [DATA_W-1:0] stall_addr = '0;
  req_lsu_op_e cur_op = LOAD;

  function automatic logic [DATA_W-1:0] mrd(input logic [DATA_W-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  function automatic logic [DATA_W-1:0] rrd(input logic [DATA_W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  task automatic chk(input string n, input logic [191:0] act, input logic [191:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic setw(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] d);
    mem[a] = d;
    ref_mem[a] = d;
  endtask

  // core side: either a fixed ready level or random backpressure
  initial begin
    core_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      core_ready_i = cr_rand ? ($urandom_range(0, 9) < 7) : cr_val;
    end
  end

  // memory responder: grant delays, read latency, lock spinning, request stability checks
  initial begin
    logic [DATA_W-1:0] wa, wd, rdv;
    logic ww;
    bit waiting, rp, lk;
    int gw, rw;
    waiting = 0; rp = 0; lk = 0; gw = 0; rw = 0; wa = '0; wd = '0; ww = 0; rdv = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      mem_gnt_i = 0;
      mem_rvalid_i = 0;
      if (!rst_ni) begin
        waiting = 0; rp = 0; lk = 0;
        continue;
      end
      if (inject) begin
        inject = 0;
        mem_rvalid_i = 1;
        mem_rdata_i = '1;
        continue;
      end
      if (lk) chk("lock_held", mem_lock_o, 1);
      if (rp) begin
        if (rw == 0) begin
          mem_rvalid_i = 1;
          mem_rdata_i = rdv;
          rp = 0;
        end else rw--;
      end else if (mem_req_o) begin
        if (waiting) chk("req_stable", {mem_addr_o, mem_wdata_o, mem_we_o}, {wa, wd, ww});
        else begin
          waiting = 1;
          wa = mem_addr_o; wd = mem_wdata_o; ww = mem_we_o;
          gw = gmode == 0 ? 0 : gmode == 1 ? 2 : $urandom_range(0, 3);
        end
        if (gw == 0 && !(stall_en && mem_addr_o == stall_addr)) begin
          waiting = 0;
          mem_gnt_i = 1;
          if (mem_we_o) begin
            mem[mem_addr_o] = mem_wdata_o;
            wr_log.push_back('{a: mem_addr_o, d: mem_wdata_o});
            if (cur_op == LOCK) begin
              chk("lock_on_write", mem_lock_o, 1);
              lk = 0;
            end
          end else begin
            rdv = mrd(mem_addr_o);
            if (cur_op == LOCK) begin
              chk("lock_on_read", mem_lock_o, 1);
              lock_reads++;
              lk = 1;
              if (spin > 0) begin
                spin--;
                if (spin == 0) mem[LOCK_ADDR] = '0;
              end
            end
            rw = gmode == 0 ? 0 : $urandom_range(0, 2);
            if (rw == 0) begin
              mem_rvalid_i = 1;
              mem_rdata_i = rdv;
            end else begin
              rp = 1;
              rw--;
            end
          end
        end else if (gw > 0) gw--;
      end
    end
  end

  // monitor: pops the scoreboard on each handshake and checks responses are held while stalled
  initial begin
    header_t ph;
    bit pv, pr;
    pv = 0; pr = 0; ph = '0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        pv = 0;
        continue;
      end
      if (pv && !pr) begin
        chk("rsp_hold_val", rsp_o.val, 1);
        if (rsp_o.val) chk("rsp_hold_hdr", rsp_o.header, ph);
      end
      if (rsp_o.val && core_ready_i) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rsp_unexpected: got %0h expected none", rsp_o.header);
        end else chk("rsp_hdr", rsp_o.header, exp_q.pop_front());
      end
      pv = rsp_o.val; pr = core_ready_i; ph = rsp_o.header;
    end
  end

  task automatic issue(input req_lsu_op_e op, input header_t h);
    header_t e;
    int n;
    n = 0;
    while (!lsu_ready_o && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) chk("ready_timeout", lsu_ready_o, 1);
    e = '0;
    case (op)
      LOAD: e = '{addr: h.addr, size: rrd(h.addr), next_addr: rrd(h.addr + WORD_BYTES)};
      EDIT_NEXT_ADDR: begin
        ref_mem[h.addr + WORD_BYTES] = h.next_addr;
        e = h;
      end
      EDIT_SIZE_AND_NEXT_ADDR: begin
        ref_mem[h.addr] = h.size;
        ref_mem[h.addr + WORD_BYTES] = h.next_addr;
        e = h;
      end
      LOCK:    ref_mem[LOCK_ADDR] = DATA_W'(1);
      UNLOCK:  ref_mem[LOCK_ADDR] = '0;
      default: e = '0;
    endcase
    exp_q.push_back(e);
    cur_op = op;
    req_i = '{header: h, lsu_op: op, val: 1'b1};
    @(posedge clk); #1;
    req_i.val = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !lsu_ready_o) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) chk("idle_timeout", exp_q.size(), 0);
  endtask

  initial begin
    header_t h;
    int cnt;
    req_lsu_op_e op;
    logic [DATA_W-1:0] top;
    req_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", lsu_ready_o, 1);
    chk("rst_rsp", rsp_o, '0);
    chk("rst_mem", {mem_req_o, mem_we_o, mem_lock_o, mem_addr_o, mem_wdata_o}, '0);
    @(negedge clk);
    rst_ni = 1;
    @(posedge clk); #1;
    chk("post_rst_ready", lsu_ready_o, 1);

    setw('h10, 'h40);
    setw('h18, 'h80);
    issue(LOAD, '{addr: 'h10, size: '0, next_addr: '0});
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!rsp_o.val && cnt < 50);
    chk("load_latency", cnt, 3);
    wait_idle();

    gmode = 1;
    wr_log.delete();
    issue(EDIT_SIZE_AND_NEXT_ADDR, '{addr: 'h80, size: 'h20, next_addr: '0});
    wait_idle();
    chk("edit_wr_count", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("edit_wr0", wr_log[0], {64'h80, 64'h20});
      chk("edit_wr1", wr_log[1], {64'h88, 64'h0});
    end

    gmode = 0;
    mem[LOCK_ADDR] = DATA_W'(1);
    spin = 3;
    lock_reads = 0;
    wr_log.delete();
    issue(LOCK, '{addr: 'h40, size: 'h1, next_addr: 'h2});
    wait_idle();
    chk("lock_reads", lock_reads, 4);
    chk("lock_word_set", mrd(LOCK_ADDR), 1);
    chk("lock_wr_count", wr_log.size(), 1);
    issue(UNLOCK, '{addr: 'h40, size: 'h1, next_addr: 'h2});
    wait_idle();
    chk("unlock_word", mrd(LOCK_ADDR), 0);

    cr_val = 0;
    @(posedge clk); #1;
    issue(LOAD, '{addr: 'h10, size: '0, next_addr: '0});
    cnt = 0;
    while (!rsp_o.val && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("bp_rsp_seen", rsp_o.val, 1);
    req_i = '{header: '{addr: 'h80, size: '0, next_addr: '0}, lsu_op: EDIT_NEXT_ADDR, val: 1'b1};
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready_low", lsu_ready_o, 0);
      chk("bp_no_mem", mem_req_o, 0);
      @(posedge clk); #1;
    end
    req_i.val = 1'b0;
    cr_val = 1;
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("bp_no_extra", {rsp_o.val, mem_req_o}, '0);

    top = '1 - WORD_BYTES + 1;
    setw(top, 'h1234);
    setw(LOCK_ADDR, 'h5A);
    issue(LOAD, '{addr: top, size: '0, next_addr: '0});
    wait_idle();
    setw(LOCK_ADDR, '0);

    stall_en = 1;
    stall_addr = 'h18;
    issue(LOAD, '{addr: 'h10, size: '0, next_addr: '0});
    cnt = 0;
    while (!(mem_req_o && mem_addr_o == 'h18) && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("rst_in_rd_next", {mem_req_o, mem_addr_o}, {1'b1, 64'h18});
    #2;
    rst_ni = 0;
    #1;
    chk("async_rst_mem", {mem_req_o, mem_we_o, mem_lock_o, mem_addr_o, mem_wdata_o}, '0);
    chk("async_rst_rsp", rsp_o, '0);
    chk("async_rst_ready", lsu_ready_o, 1);
    void'(exp_q.pop_back());
    stall_en = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1;
    inject = 1;
    repeat (3) begin
      @(negedge clk);
      chk("late_rvalid_ignored", {rsp_o.val, mem_req_o, lsu_ready_o}, 3'b001);
    end
    @(posedge clk); #1;
    issue(LOAD, '{addr: 'h10, size: '0, next_addr: '0});
    wait_idle();

    gmode = 2;
    cr_rand = 1;
    for (int i = 0; i < 40; i++) begin
      h.addr = $urandom_range(0, 7) == 0 ? top : DATA_W'($urandom_range(2, 20) * 16);
      h.size = {$urandom, $urandom};
      h.next_addr = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: op = LOAD;
        1: op = EDIT_NEXT_ADDR;
        2: op = EDIT_SIZE_AND_NEXT_ADDR;
        3: op = rrd(LOCK_ADDR) == '0 ? LOCK : UNLOCK;
        4: op = UNLOCK;
        default: op = req_lsu_op_e'($urandom_range(5, 7));
      endcase
      issue(op, h);
    end
    cr_rand = 0;
    cr_val = 1;
    wait_idle();
    foreach (ref_mem[k]) chk("mem_final", mrd(k), ref_mem[k]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
